// File: rtl/regfile_dump_reader_pkg.sv
// Types and default geometry shared by the register file and its dump reader.
package regfile_dump_reader_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int REG_DATA_W    = 32;
    localparam int NUM_ARCH_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dumpState_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Freezes the core and streams registers 0..NUM_REGS-1 out over valid/ready,
// reading each word through the register file's combinational read port.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              freeze,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dumpState_t        state;
    dumpState_t        stateNext;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idxNext;
    logic              xfer;

    // Handshake outputs are decoded from state so they never lag the FSM.
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (idx == LAST_IDX);
    assign busy      = (state != IDLE);
    assign freeze    = busy;
    assign done      = (state == DONE);
    assign rf_addr   = (state == IDLE) ? '0 : idx;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        case (state)
            IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    stateNext = READ;
                    idxNext   = '0;
                end
            end
            READ: begin
                if (abort) begin
                    stateNext = IDLE;
                    idxNext   = '0;
                end else begin
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    stateNext = IDLE;
                    idxNext   = '0;
                end else if (xfer) begin
                    if (idx == LAST_IDX) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = READ;
                        idxNext   = idx + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
        endcase
    end

    // The capture register only loads in READ, so the word holds through stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            if (state == READ) begin
                out_data  <= rf_data;
                out_index <= idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed-plus-random bench for regfile_dump_reader against a snapshot model of the register file.
module tb_regfile_dump_reader;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          freeze;
    logic          done;

    logic [DW-1:0] regs [N];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rf_data = regs[rf_addr];

    regfile_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .freeze    (freeze),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core-side write port: x0 is hardwired, and freeze gates regWrite.
    task automatic coreWrite(input int a, input logic [DW-1:0] v);
        if (a != 0 && !freeze) regs[a] = v;
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_freeze"},    freeze,    0);
        chk({tag, "_valid"},     out_valid, 0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_last"},      out_last,  0);
        chk({tag, "_rf_addr"},   rf_addr,   0);
    endtask

    task automatic checkReset(input string tag);
        checkIdle(tag);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_index"}, out_index, 0);
    endtask

    // One dump from start; optional abort at an index (ready low), abort on the
    // last transfer, a stray start at an index, or an async reset at an index.
    task automatic dump(input int pct, input int abortIdx, input bit abortLast,
                        input int restartIdx, input int rstIdx, input int expCycles);
        logic [DW-1:0] snap [N];
        int nextIdx;
        int cycles;
        bit stalled;
        for (int i = 0; i < N; i++) snap[i] = regs[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        chk("start_busy",   busy,      1);
        chk("start_freeze", freeze,    1);
        chk("start_valid",  out_valid, 0);
        nextIdx = 0;
        stalled = 1'b0;
        for (int budget = 0; budget < 3000; budget++) begin
            coreWrite($urandom_range(1, N - 1), $urandom);
            if (stalled) chk("stall_valid_held", out_valid, 1);
            if (out_valid) begin
                chk("index", out_index, nextIdx);
                chk("data",  out_data,  snap[nextIdx]);
                chk("last",  out_last,  (nextIdx == N - 1));
                if (nextIdx == rstIdx) begin
                    rst = 1'b1;
                    #1;
                    checkReset("async_rst");
                    #2;
                    rst = 1'b0;
                    return;
                end
                if (abortLast && nextIdx == N - 1) begin
                    out_ready = 1'b1;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    out_ready = 1'b0;
                    $display("xfer idx=%0d data=%08h (with abort)", nextIdx, snap[nextIdx]);
                    checkIdle("abort_last");
                    tick();
                    chk("abort_last_no_done", done, 0);
                    return;
                end
                if (nextIdx == abortIdx) begin
                    out_ready = 1'b0;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    checkIdle("abort_send");
                    tick();
                    chk("abort_send_no_done", done, 0);
                    return;
                end
                out_ready = ($urandom_range(0, 99) < pct);
                start = (nextIdx == restartIdx);
                tick();
                start = 1'b0;
                cycles++;
                if (out_ready) begin
                    $display("xfer idx=%0d data=%08h", nextIdx, snap[nextIdx]);
                    nextIdx++;
                    stalled = 1'b0;
                    if (nextIdx == N) begin
                        chk("done_pulse", done, 1);
                        chk("done_valid", out_valid, 0);
                        if (expCycles > 0) chk("dump_cycles", cycles, expCycles);
                        out_ready = 1'b0;
                        tick();
                        chk("done_single", done, 0);
                        chk("done_idle", busy, 0);
                        return;
                    end
                end else begin
                    stalled = 1'b1;
                end
            end else begin
                chk("read_busy",    busy,    1);
                chk("read_rf_addr", rf_addr, nextIdx);
                out_ready = ($urandom_range(0, 99) < pct);
                tick();
                cycles++;
            end
        end
        chk("dump_timeout", nextIdx, N);
    endtask

    initial begin
        regs[0] = '0;
        for (int i = 1; i < N; i++) regs[i] = 32'hA5A5_0000 + i;

        tick();
        tick();
        checkReset("reset");
        rst = 1'b0;
        tick();
        checkReset("post_reset");

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkIdle("abort_with_start");

        dump(100, -1, 1'b0, -1, -1, 2 * N + 1);

        for (int i = 1; i < N; i++) coreWrite(i, $urandom);
        dump(30, -1, 1'b0, -1, -1, 0);
        dump(30, -1, 1'b0, -1, -1, 0);

        dump(50, 10, 1'b0, -1, -1, 0);
        dump(100, -1, 1'b0, -1, -1, 2 * N + 1);

        dump(60, -1, 1'b1, -1, -1, 0);
        dump(100, -1, 1'b0, 5, -1, 2 * N + 1);

        dump(40, -1, 1'b0, -1, 17, 0);
        coreWrite(17, 32'hDEAD_BEEF);
        chk("core_write_x17", regs[17], 32'hDEAD_BEEF);
        dump(100, -1, 1'b0, -1, -1, 2 * N + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Read-side sequencer for the 32 x 32-bit register file. On a start request it freezes the core, reads every architectural register x0..x31 in order through one combinational read port, and streams each word out over a valid/ready handshake. It sits between the register file and a debug/trace consumer, and asserts a freeze output to the core so the snapshot stays coherent.

## Interface
- NUM_REGS, default 32: registers dumped, indices 0..NUM_REGS-1.
- ADDR_W, default 5: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, default 32: register data width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- abort  in  1  cancel an in-progress dump.
- rf_addr  out  ADDR_W  read address, drives the register file's rs-style read port.
- rf_data  in  DATA_W  combinational read data for rf_addr.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  captured register value.
- out_index  out  ADDR_W  register number of out_data.
- out_last  out  1  the current word is index NUM_REGS-1.
- busy  out  1  high in any state other than IDLE.
- freeze  out  1  equals busy; the core must suppress regWrite while high.
- done  out  1  one-cycle pulse after the last word transfers.

## Operation
- States: IDLE, READ, SEND, DONE. Encoding 2 bits.
- IDLE: rf_addr=0, out_valid=0. If start=1, set idx=0 and go to READ.
- READ: rf_addr=idx. At the clock edge, out_data<=rf_data and out_index<=idx, then go to SEND.
- SEND: out_valid=1, and out_last=(idx==NUM_REGS-1). A transfer occurs when out_valid&&out_ready.
  - On transfer with idx<NUM_REGS-1: idx<=idx+1, go to READ.
  - On transfer with idx==NUM_REGS-1: go to DONE.
  - With no transfer: hold all outputs stable.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored. There is no queuing.
- abort=1 in READ, SEND or DONE goes to IDLE on the next edge. No done pulse is produced and idx is cleared.
- abort and a transfer in the same SEND cycle: the transfer counts as completed, abort still wins, next state is IDLE, no done.
- abort together with start in IDLE: abort has priority and the unit stays in IDLE.
- idx is ADDR_W bits and never wraps. The terminal compare is against NUM_REGS-1.
- x0 is read like any other register. The register file already returns 0 for it.

## Timing
- Reset state: IDLE, idx=0, rf_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, freeze=0, done=0.
- Reset mid-dump takes effect immediately (asynchronous). The partial stream is dropped.
- start at edge N: busy/freeze high after edge N, and first out_valid high after edge N+1.
- Each word takes at least 2 cycles: 1 READ plus at least 1 SEND.
- Minimum full dump is 2*NUM_REGS+1 cycles from start to done (65 cycles at the defaults) with out_ready tied high.
- out_valid is never deasserted without a transfer or an abort/reset.
- out_data, out_index and out_last are stable while out_valid && !out_ready.
- rf_data is sampled only in READ, one cycle after freeze rises at the earliest. Writes in flight at the edge where start is sampled complete before the first READ capture.
- All outputs are registered, except rf_addr, out_valid, out_last, busy, freeze and done, which are decoded from state and idx.

## Structure
- Shared package holds:
  - the state enum (IDLE/READ/SEND/DONE),
  - defaults REG_ADDR_W=5, REG_DATA_W=32 and NUM_ARCH_REGS=32, also used by the register file.
- Single module, no sub-modules. The FSM, the idx counter and the output capture register share one always block plus next-state logic.
- At top level, freeze ANDs into the core's regWrite and PC enable.

## Test plan
- Preload x_i = 32'hA5A5_0000 + i. Pulse start, hold out_ready=1. Required: 32 transfers, index 0..31, data 0, A5A5_0001 .. A5A5_001F; out_last only on index 31; done one cycle after; 65 cycles total.
- Random out_ready, 30% high. Required: no dropped or duplicated word, and outputs stable during every stall cycle.
- Assert abort during SEND of index 10 with out_ready=0. Required: IDLE next cycle, no done, and a new start restarts at index 0.
- Assert abort coincident with the transfer of index 31. Required: IDLE, no done pulse.
- Pulse start again while busy at index 5. Required: ignored, and the sequence continues at index 6.
- Assert rst at index 17. Required: all outputs at reset values immediately. Then a core write to x17 followed by start. Required: the dump shows the new value.
